cmd_seq_proc: RTL
=================

// Module: cmd_seq_proc
// PURPOSE
//  Parametrised successor of the Knight command processor. Decodes 16-bit UART commands
//  {op[15:12], hdg[11:4], sq[3:0]} into a QDEPTH-deep command queue so the host can stream
//  a tour's moves back-to-back. Adds an immediate ABORT opcode, a square-count stall timeout,
//  a clamped frwrd ramp and a 2-bit response code. Sits between UART wrapper, PID and inertial.
// PARAMETERS
//  QDEPTH    4      command queue entries, power of 2, >=2
//  FRWRD_W   10     width of frwrd
//  INC_STEP  32     frwrd increment per heading_rdy in RAMP_UP
//  DEC_STEP  64     frwrd decrement per heading_rdy in RAMP_DOWN
//  MAX_FRWRD 768    frwrd ceiling, < 2**FRWRD_W
//  ERR_TOL   48     |error| < ERR_TOL leaves HEAD
//  NUDGE     12'h1FF IR nudge magnitude: +NUDGE on lftIR, -NUDGE on rghtIR (lftIR wins)
//  TMO_CYC   2**20  max clocks between cntrIR rises in RAMP_UP before timeout
// PORTS
//  clk         in  1   clock
//  rst         in  1   async reset, active-high
//  cmd         in  16  command word, valid while cmd_rdy
//  cmd_rdy     in  1   command available from UART wrapper
//  clr_cmd_rdy out 1   command consumed (comb: cmd_rdy & (op==ABORT | ~q_full))
//  heading     in  12  signed heading from inertial
//  heading_rdy in  1   new heading valid; frwrd updates only on this strobe
//  cal_done    in  1   calibration finished
//  lftIR,cntrIR,rghtIR in 1 each  guard/line IR sensors
//  strt_cal    out 1   1-cycle pulse on CAL dispatch
//  moving      out 1   high in HEAD/RAMP_UP/RAMP_DOWN
//  frwrd       out FRWRD_W  forward speed to PID
//  error       out 12  signed heading error to PID
//  tour_go     out 1   1-cycle pulse on TOUR dispatch
//  fanfare_go  out 1   1-cycle pulse with send_resp when completed move op==3, resp_code==00
//  send_resp   out 1   1-cycle pulse: command finished
//  resp_code   out 2   valid with send_resp: 00 ok, 01 timeout, 10 aborted
//  q_count     out clog2(QDEPTH)+1  queued entries; q_full = (q_count==QDEPTH)
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE, frwrd=0, desired_heading=0, all pulses/resp_code=0.
//  Opcodes: 0 CAL, 2 MOVE, 3 MOVE+fanfare, 4 TOUR, F ABORT; others consumed and dropped.
//  Intake: non-ABORT pushed on clk when cmd_rdy & ~q_full; full -> no clr_cmd_rdy (back-pressure).
//   Push+pop same cycle legal, q_count unchanged. ABORT never queued, accepted even when full.
//  Dispatch: IDLE & q_count!=0 pops head; next state by op, 1 cycle after push at earliest.
//  FSM IDLE->CAL (strt_cal) ->IDLE on cal_done (send_resp, 00).
//   IDLE->TOUR op: tour_go pulse, stay IDLE, no send_resp.
//   IDLE->HEAD (move): latch desired = hdg==0 ? 0 : {hdg,4'hF}; target=2*sq; frwrd:=0.
//   HEAD->RAMP_UP when -ERR_TOL < error < ERR_TOL; clear sq count and timer.
//   RAMP_UP: inc frwrd, clamp to MAX_FRWRD; count cntrIR rising edges (1-flop edge detect);
//    count==target -> RAMP_DOWN (sq=0 exits after 1 cycle); timer reaches TMO_CYC -> RAMP_DOWN, code 01.
//   RAMP_DOWN: dec frwrd, clamp at 0; frwrd==0 -> IDLE, send_resp with latched code.
//  error = heading - desired + nudge, 12-bit two's complement wrap, combinational.
//  ABORT: flushes queue same edge. IDLE: send_resp/10 next cycle. CAL/HEAD: ->IDLE, send_resp/10,
//   frwrd=0. RAMP_UP: ->RAMP_DOWN, code 10. RAMP_DOWN: code becomes 10. Abort beats timeout.
//  cntrIR rise and timeout same cycle: rise wins, timer restarts.
//  Mid-operation rst: everything returns to reset values immediately, queue lost.
// TESTING
//  T1 CAL 0x0000, cal_done 20 clks later -> strt_cal 1 pulse, send_resp resp_code=00, q_count 0.
//  T2 MOVE 0x2002, heading=0, 4 cntrIR pulses -> frwrd ramps 32/step to 768, ramps to 0, resp 00.
//  T3 Stream 5 moves while QDEPTH=4 busy -> 5th held (clr_cmd_rdy=0) until pop; all 5 execute in order.
//  T4 MOVE 0x3FF1 then stop cntrIR, TMO_CYC=1000 -> RAMP_DOWN after 1000 clks, resp 01, no fanfare.
//  T5 ABORT 0xF000 during RAMP_UP with 2 queued -> q_count 0, frwrd to 0, one send_resp code 10.
//  T6 lftIR=1, heading=desired -> error=0x1FF; lftIR&rghtIR -> 0x1FF; rghtIR only -> 0xE01.

Source files
------------

// File: rtl/cmd_seq_if.sv
// Command/response handshake between the UART wrapper (master) and the command sequencer (slave).
interface cmd_seq_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [1:0]  resp_code;

  modport master (output cmd, output cmd_rdy, input clr_cmd_rdy, input send_resp, input resp_code);
  modport slave  (input cmd, input cmd_rdy, output clr_cmd_rdy, output send_resp, output resp_code);
endinterface

// File: rtl/cmd_seq_proc.sv
// Queued command sequencer: decodes UART commands into CAL/MOVE/TOUR actions, drives the
// forward-speed ramp and heading error, and reports completion with a 2-bit response code.
module cmd_seq_proc #(
  parameter int          QDEPTH    = 4,
  parameter int          FRWRD_W   = 10,
  parameter int          INC_STEP  = 32,
  parameter int          DEC_STEP  = 64,
  parameter int          MAX_FRWRD = 768,
  parameter int          ERR_TOL   = 48,
  parameter logic [11:0] NUDGE     = 12'h1FF,
  parameter int          TMO_CYC   = 2**20
) (
  input  logic                      clk,
  input  logic                      rst,
  cmd_seq_if.slave                  bus,
  input  logic signed [11:0]        heading,
  input  logic                      heading_rdy,
  input  logic                      cal_done,
  input  logic                      lftIR,
  input  logic                      cntrIR,
  input  logic                      rghtIR,
  output logic                      strt_cal,
  output logic                      moving,
  output logic [FRWRD_W-1:0]        frwrd,
  output logic signed [11:0]        error,
  output logic                      tour_go,
  output logic                      fanfare_go,
  output logic [$clog2(QDEPTH):0]   q_count
);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic signed [12:0] TOL_P = 13'(ERR_TOL);
  localparam logic signed [12:0] TOL_N = -TOL_P;

  typedef enum logic [2:0] {IDLE, CAL, HEAD, RAMP_UP, RAMP_DOWN} state_t;

  state_t             state;
  logic [15:0]        q_mem [QDEPTH];
  logic [QW-1:0]      wr_ptr, rd_ptr;
  logic [15:0]        head_cmd;
  logic               is_abort, q_full, push, pop;
  logic signed [11:0] desired;
  logic [11:0]        nudge;
  logic signed [12:0] err_x;
  logic               in_tol;
  logic [4:0]         target, sq_cnt, next_cnt;
  logic [TW-1:0]      tmr;
  logic               cntr_q, rise;
  logic [1:0]         code;
  logic               fan_op;

  function automatic logic [FRWRD_W-1:0] ramp_inc(input logic [FRWRD_W-1:0] f);
    logic [FRWRD_W:0] s;
    s = {1'b0, f} + (FRWRD_W+1)'(INC_STEP);
    return (s >= (FRWRD_W+1)'(MAX_FRWRD)) ? FRWRD_W'(MAX_FRWRD) : s[FRWRD_W-1:0];
  endfunction

  function automatic logic [FRWRD_W-1:0] ramp_dec(input logic [FRWRD_W-1:0] f);
    return (f <= FRWRD_W'(DEC_STEP)) ? '0 : f - FRWRD_W'(DEC_STEP);
  endfunction

  assign is_abort        = bus.cmd_rdy && (bus.cmd[15:12] == 4'hF);
  assign q_full          = (q_count == CW'(QDEPTH));
  assign push            = bus.cmd_rdy && (bus.cmd[15:12] != 4'hF) && !q_full;
  // ABORT wins over dispatch so an abort in IDLE never starts a queued command.
  assign pop             = (state == IDLE) && (q_count != '0) && !is_abort;
  assign bus.clr_cmd_rdy = bus.cmd_rdy && ((bus.cmd[15:12] == 4'hF) || !q_full);
  assign head_cmd        = q_mem[rd_ptr];

  always_comb begin
    nudge = 12'h000;
    if (lftIR)       nudge = NUDGE;
    else if (rghtIR) nudge = -NUDGE;
  end

  assign error    = 12'(heading - desired + nudge);
  assign err_x    = 13'(error);
  assign in_tol   = (err_x > TOL_N) && (err_x < TOL_P);
  assign rise     = cntrIR && !cntr_q;
  assign next_cnt = sq_cnt + 5'(rise);
  assign moving   = (state == HEAD) || (state == RAMP_UP) || (state == RAMP_DOWN);

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= bus.cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (is_abort) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frwrd      <= '0;
      desired    <= '0;
      target     <= '0;
      sq_cnt     <= '0;
      tmr        <= '0;
      code       <= 2'b00;
      fan_op     <= 1'b0;
      cntr_q     <= 1'b0;
      strt_cal   <= 1'b0;
      tour_go    <= 1'b0;
      fanfare_go <= 1'b0;
      bus.send_resp <= 1'b0;
      bus.resp_code <= 2'b00;
    end else begin
      strt_cal      <= 1'b0;
      tour_go       <= 1'b0;
      fanfare_go    <= 1'b0;
      bus.send_resp <= 1'b0;
      cntr_q        <= cntrIR;
      case (state)
        IDLE: begin
          if (is_abort) begin
            bus.send_resp <= 1'b1;
            bus.resp_code <= 2'b10;
          end else if (pop) begin
            case (head_cmd[15:12])
              4'h0: begin
                strt_cal <= 1'b1;
                state    <= CAL;
              end
              4'h2, 4'h3: begin
                desired <= (head_cmd[11:4] == 8'h00) ? 12'sh000 : {head_cmd[11:4], 4'hF};
                target  <= {head_cmd[3:0], 1'b0};
                frwrd   <= '0;
                code    <= 2'b00;
                fan_op  <= (head_cmd[15:12] == 4'h3);
                state   <= HEAD;
              end
              4'h4:    tour_go <= 1'b1;
              default: ;
            endcase
          end
        end
        CAL: begin
          if (is_abort || cal_done) begin
            state         <= IDLE;
            bus.send_resp <= 1'b1;
            bus.resp_code <= is_abort ? 2'b10 : 2'b00;
          end
        end
        HEAD: begin
          if (is_abort) begin
            state         <= IDLE;
            frwrd         <= '0;
            bus.send_resp <= 1'b1;
            bus.resp_code <= 2'b10;
          end else if (in_tol) begin
            sq_cnt <= '0;
            tmr    <= '0;
            state  <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (heading_rdy) frwrd <= ramp_inc(frwrd);
          sq_cnt <= next_cnt;
          tmr    <= rise ? '0 : tmr + TW'(1);
          // Priority: abort, then square count reached, then stall timeout (a rise restarts the timer).
          if (is_abort) begin
            code  <= 2'b10;
            state <= RAMP_DOWN;
          end else if (next_cnt >= target) begin
            state <= RAMP_DOWN;
          end else if (!rise && (tmr == TW'(TMO_CYC - 1))) begin
            code  <= 2'b01;
            state <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (is_abort) code <= 2'b10;
          if (frwrd == '0) begin
            state         <= IDLE;
            bus.send_resp <= 1'b1;
            bus.resp_code <= is_abort ? 2'b10 : code;
            fanfare_go    <= fan_op && !is_abort && (code == 2'b00);
          end else if (heading_rdy) begin
            frwrd <= ramp_dec(frwrd);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
